pipe_ctrl: RTL

Pipeline hazard controller for the five-stage core. It generates the per-stage hold and scour flags that drive the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, branch mispredicts, multi-cycle EX operations (mul/div) and data-bus wait states. It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage hold/scour flags, fetch redirect, multi-cycle wait FSM
// with watchdog, and saturating stall/flush performance counters.
module pipe_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_re,
    input  logic                  id_rs2_re,
    input  logic                  ex_is_load,
    input  logic                  ex_reg_we,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_branch_valid,
    input  logic                  ex_taken,
    input  logic                  ex_jump_bp,
    input  logic [ADDR_W-1:0]     ex_target,
    input  logic [ADDR_W-1:0]     ex_pc,
    input  logic                  ex_mc_start,
    input  logic                  ex_mc_done,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_hold_flag,
    output logic                  id_hold_flag,
    output logic                  id_scour_flag,
    output logic                  ex_hold_flag,
    output logic                  ex_scour_flag,
    output logic                  mem_hold_flag,
    output logic                  mem_scour_flag,
    output logic                  redirect_flag,
    output logic [ADDR_W-1:0]     redirect_addr,
    output logic [1:0]            ctrl_state_o,
    output logic                  mc_timeout_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int unsigned WdW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMcWait = 2'd1
    } state_e;

    state_e           state_q, state_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic memstall, mispred, lduse;

    assign memstall = mem_req & ~mem_ready;
    assign mispred  = ex_branch_valid & (ex_taken != ex_jump_bp);
    assign lduse    = ex_is_load & ex_reg_we & (ex_rd_addr != '0) &
                      ((id_rs1_re & (id_rs1_addr == ex_rd_addr)) |
                       (id_rs2_re & (id_rs2_addr == ex_rd_addr)));

    always_comb begin
        state_d        = state_q;
        wd_d           = wd_q;
        pc_hold_flag   = 1'b0;
        id_hold_flag   = 1'b0;
        id_scour_flag  = 1'b0;
        ex_hold_flag   = 1'b0;
        ex_scour_flag  = 1'b0;
        mem_hold_flag  = 1'b0;
        mem_scour_flag = 1'b0;
        redirect_flag  = 1'b0;
        redirect_addr  = '0;
        mc_timeout_o   = 1'b0;

        if (memstall) begin
            pc_hold_flag  = 1'b1;
            id_hold_flag  = 1'b1;
            ex_hold_flag  = 1'b1;
            mem_hold_flag = 1'b1;
        end else if (state_q == StMcWait) begin
            if (ex_mc_done) begin
                state_d = StRun;
            end else if (wd_q == WdW'(MC_TIMEOUT - 1)) begin
                // Watchdog expiry releases the pipeline exactly as a done pulse would.
                mc_timeout_o = 1'b1;
                state_d      = StRun;
            end else begin
                pc_hold_flag   = 1'b1;
                id_hold_flag   = 1'b1;
                ex_hold_flag   = 1'b1;
                mem_scour_flag = 1'b1;
                wd_d           = wd_q + 1'b1;
            end
        end else if (mispred) begin
            redirect_flag = 1'b1;
            id_scour_flag = 1'b1;
            ex_scour_flag = 1'b1;
            redirect_addr = ex_taken ? ex_target : ex_pc + ADDR_W'(4);
        end else if (ex_mc_start && !ex_branch_valid) begin
            pc_hold_flag   = 1'b1;
            id_hold_flag   = 1'b1;
            ex_hold_flag   = 1'b1;
            mem_scour_flag = 1'b1;
            state_d        = StMcWait;
            wd_d           = '0;
        end else if (lduse) begin
            pc_hold_flag  = 1'b1;
            id_hold_flag  = 1'b1;
            ex_scour_flag = 1'b1;
        end

        if (!rst_n) begin
            pc_hold_flag   = 1'b0;
            id_hold_flag   = 1'b0;
            id_scour_flag  = 1'b0;
            ex_hold_flag   = 1'b0;
            ex_scour_flag  = 1'b0;
            mem_hold_flag  = 1'b0;
            mem_scour_flag = 1'b0;
            redirect_flag  = 1'b0;
            redirect_addr  = '0;
            mc_timeout_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            wd_q    <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (pc_hold_flag && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (redirect_flag && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign ctrl_state_o = state_q;
    assign stall_cnt_o  = stall_q;
    assign flush_cnt_o  = flush_q;

endmodule
